// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types and constants for the CPU bus arbiter.
package cpu_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
    localparam logic [31:0] ABORT_RDATA            = 32'hFFFF_FFFF;

    // Timeout counter width: wide enough for TIMEOUT_CYCLES, clamped to 8..16 bits.
    function automatic int unsigned timeout_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        if (w < 8) begin
            w = 8;
        end else if (w > 16) begin
            w = 16;
        end
        return w;
    endfunction

endpackage

// File: rtl/cpu_bus_arbiter.sv
// Two-port CPU bus arbiter: I-cache refill port (A, read-only) and data
// port (B, read/write) share one bus. Round-robin on ties, grant held until
// i_bus_ready, responses forwarded combinationally.
// Optional macro CPU_BUS_ARBITER_TIMEOUT_EN adds a per-grant timeout that
// aborts the transaction with all-ones read data and a sticky o_timeout.
module cpu_bus_arbiter
    import cpu_bus_arbiter_pkg::*;
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
`endif
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_pa_request,
    input  logic [31:0] i_pa_address,
    output logic [31:0] o_pa_rdata,
    output logic        o_pa_ready,
    input  logic        i_pb_request,
    input  logic        i_pb_rw,
    input  logic [31:0] i_pb_address,
    input  logic [31:0] i_pb_wdata,
    output logic [31:0] o_pb_rdata,
    output logic        o_pb_ready,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_timeout
);

    state_e      state;
    state_e      state_next;
    port_sel_e   last_grant;
    logic        bus_rw_q;
    logic [31:0] bus_address_q;
    logic [31:0] bus_wdata_q;
    logic        abort;
    logic        complete;
    logic [31:0] resp_data;

    assign complete = i_bus_ready | abort;

    // Next-state: arbitrate in IDLE, leave a grant on completion or abort.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_pa_request && (!i_pb_request || last_grant == PORT_B)) begin
                    state_next = GRANT_A;
                end else if (i_pb_request) begin
                    state_next = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                if (complete) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winning port's command into the bus registers on grant entry.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            last_grant    <= PORT_B;
            bus_rw_q      <= 1'b0;
            bus_address_q <= '0;
            bus_wdata_q   <= '0;
        end else if (state == IDLE && state_next == GRANT_A) begin
            last_grant    <= PORT_A;
            bus_rw_q      <= 1'b0;
            bus_address_q <= i_pa_address;
            bus_wdata_q   <= '0;
        end else if (state == IDLE && state_next == GRANT_B) begin
            last_grant    <= PORT_B;
            bus_rw_q      <= i_pb_rw;
            bus_address_q <= i_pb_address;
            bus_wdata_q   <= i_pb_wdata;
        end
    end

    assign o_bus_request = (state != IDLE);
    assign o_bus_rw      = bus_rw_q;
    assign o_bus_address = bus_address_q;
    assign o_bus_wdata   = bus_wdata_q;

    // Route completion and read data to the granted port only; a bus
    // response coinciding with reset is swallowed.
    always_comb begin
        o_pa_ready = 1'b0;
        o_pb_ready = 1'b0;
        o_pa_rdata = '0;
        o_pb_rdata = '0;
        resp_data  = abort ? ABORT_RDATA : i_bus_rdata;
        if (state == GRANT_A) begin
            o_pa_ready = complete && !i_reset;
            o_pa_rdata = resp_data;
        end
        if (state == GRANT_B) begin
            o_pb_ready = complete && !i_reset;
            o_pb_rdata = resp_data;
        end
    end

`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = timeout_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;
    logic             timeout_q;

    // Counter is zero in every IDLE cycle, so it starts at 0 on grant entry;
    // value TIMEOUT_CYCLES-1 therefore marks the TIMEOUT_CYCLES-th granted cycle.
    assign abort = (state != IDLE) && !i_bus_ready &&
                   (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Grant-cycle counter and sticky timeout flag.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == IDLE) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
            if (abort) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    assign abort     = 1'b0;
    assign o_timeout = 1'b0;
`endif

endmodule
